// File: rtl/fir_mac_pkg.sv
// fir_mac_pkg: shared FSM state type and width/rounding helpers for the FIR MAC engine.
// Honours FIR_SATURATE_EN: clamp instead of two's-complement wrap on output.
package fir_mac_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    MAC,
    DRAIN,
    OUT
  } state_e;

  localparam int MAXW      = 128;
  localparam int DRAIN_CYC = 3;

  function automatic int acc_width(
    input int sw,
    input int cw,
    input int taps
  );
    return sw + cw + $clog2(taps);
  endfunction

  // Result is sign-extended from ow bits so callers may simply truncate.
  function automatic logic signed [MAXW-1:0] round_shift_reduce(
    input logic signed [MAXW-1:0] acc,
    input int                     shift,
    input int                     ow
  );
    logic signed [MAXW-1:0] r;
`ifdef FIR_SATURATE_EN
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
`endif
    r = acc;
    if (shift > 0)
      r = r + (MAXW'(1) <<< (shift - 1));
    r = r >>> shift;
`ifdef FIR_SATURATE_EN
    hi = (MAXW'(1) <<< (ow - 1)) - MAXW'(1);
    lo = -hi - MAXW'(1);
    if (r > hi)
      r = hi;
    else if (r < lo)
      r = lo;
`else
    r = (r <<< (MAXW - ow)) >>> (MAXW - ow);
`endif
    return r;
  endfunction

endpackage

// File: rtl/fir_lane_mac.sv
// fir_lane_mac: one lane of the engine -- registered product, then
// accumulator that loads on tap 0 and adds on every later tap.
module fir_lane_mac
  import fir_mac_pkg::*;
#(
  parameter int SW = 16,
  parameter int CW = 16,
  parameter int AW = 34
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 first_i,
  input  logic signed [SW-1:0] sample_i,
  input  logic signed [CW-1:0] coef_i,
  output logic signed [AW-1:0] acc_o
);

  localparam int PW = SW + CW;

  logic signed [PW-1:0] prod_q;
  logic                 pv_q;
  logic                 pf_q;
  logic signed [AW-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      pf_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      pv_q <= en_i;
      pf_q <= first_i;
      if (en_i)
        prod_q <= PW'(sample_i) * PW'(coef_i);
      if (pv_q)
        acc_q <= pf_q ? AW'(prod_q)
                      : acc_q + AW'(prod_q);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: multi-lane FIR MAC over an external circular delay-line RAM.
// Define FIR_SATURATE_EN to clamp results instead of wrapping.
module fir_mac_engine
  import fir_mac_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int LANES        = 8,
  parameter int TAPS         = 1024,
  parameter int OUT_WIDTH    = 16,
  parameter int OUT_SHIFT    = 15
) (
  input  logic                          clkIn,
  input  logic                          nResetIn,
  input  logic [LANES*SAMPLE_WIDTH-1:0] sampleIn,
  input  logic                          sampleValidIn,
  output logic                          sampleReadyOut,
  output logic [$clog2(TAPS)-1:0]       coefAddrOut,
  input  logic [COEF_WIDTH-1:0]         coefDataIn,
  output logic [$clog2(TAPS)-1:0]       bufAddrOut,
  output logic                          bufWrenOut,
  output logic [LANES*SAMPLE_WIDTH-1:0] bufWrDataOut,
  input  logic [LANES*SAMPLE_WIDTH-1:0] bufDataIn,
  output logic [LANES*OUT_WIDTH-1:0]    resultOut,
  output logic                          resultValidOut,
  input  logic                          resultReadyIn
);

  localparam int AW    = $clog2(TAPS);
  localparam int FW    = LANES * SAMPLE_WIDTH;
  localparam int RW    = LANES * OUT_WIDTH;
  localparam int ACC_W = acc_width(SAMPLE_WIDTH, COEF_WIDTH, TAPS);

  localparam logic [AW:0]   TAPS_C     = (AW+1)'(TAPS);
  localparam logic [AW:0]   ONE_C      = (AW+1)'(1);
  localparam logic [AW:0]   LAST_K     = (AW+1)'(TAPS - 1);
  localparam logic [AW:0]   DRAIN_LAST = (AW+1)'(DRAIN_CYC - 1);
  localparam logic [AW-1:0] PTR_LAST   = AW'(TAPS - 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  state_e          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            ready_q, ready_d;
  logic            wren_q, wren_d;
  logic [AW-1:0]   baddr_q, baddr_d;
  logic [AW-1:0]   caddr_q, caddr_d;
  logic [FW-1:0]   wdata_q, wdata_d;
  logic            rd_v_q, rd_v_d;
  logic            rd_f_q, rd_f_d;
  logic            dat_v_q;
  logic            dat_f_q;
  logic            valid_q, valid_d;
  logic [RW-1:0]   res_q, res_d;

  logic [AW:0]     kx;
  logic [AW:0]     wp_ext;
  logic [AW-1:0]   tap_addr;

  logic signed [ACC_W-1:0]     acc [LANES];
  logic        [OUT_WIDTH-1:0] red [LANES];

  // Tap index about to be issued; delay-line slot is (wrPtr - k) mod TAPS.
  always_comb begin
    kx       = (state_q == WRITE) ? '0 : cnt_q + ONE_C;
    wp_ext   = {1'b0, wr_ptr_q};
    tap_addr = (kx > wp_ext) ? AW'(wp_ext + TAPS_C - kx)
                             : AW'(wp_ext - kx);
  end

  // Output-side registers are loaded with the values of the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    ready_d  = 1'b0;
    wren_d   = 1'b0;
    baddr_d  = '0;
    caddr_d  = '0;
    wdata_d  = wdata_q;
    rd_v_d   = 1'b0;
    rd_f_d   = 1'b0;
    valid_d  = valid_q;
    res_d    = res_q;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q == TAPS_C) begin
          state_d = IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          wren_d  = 1'b1;
          baddr_d = AW'(cnt_q);
          wdata_d = '0;
          cnt_d   = cnt_q + ONE_C;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        if (sampleValidIn && ready_q) begin
          state_d = WRITE;
          ready_d = 1'b0;
          wren_d  = 1'b1;
          baddr_d = wr_ptr_q;
          wdata_d = sampleIn;
        end
      end
      WRITE: begin
        state_d = MAC;
        cnt_d   = '0;
        rd_v_d  = 1'b1;
        rd_f_d  = 1'b1;
        baddr_d = tap_addr;
        caddr_d = AW'(kx);
      end
      MAC: begin
        if (cnt_q == LAST_K) begin
          state_d  = DRAIN;
          cnt_d    = '0;
          wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0
                                            : wr_ptr_q + PTR_ONE;
        end else begin
          cnt_d   = kx;
          rd_v_d  = 1'b1;
          baddr_d = tap_addr;
          caddr_d = AW'(kx);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = OUT;
          cnt_d   = '0;
          valid_d = 1'b1;
          for (int l = 0; l < LANES; l++)
            res_d[l*OUT_WIDTH +: OUT_WIDTH] = red[l];
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      OUT: begin
        if (valid_q && resultReadyIn) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      ready_q  <= 1'b0;
      wren_q   <= 1'b0;
      baddr_q  <= '0;
      caddr_q  <= '0;
      wdata_q  <= '0;
      rd_v_q   <= 1'b0;
      rd_f_q   <= 1'b0;
      dat_v_q  <= 1'b0;
      dat_f_q  <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      ready_q  <= ready_d;
      wren_q   <= wren_d;
      baddr_q  <= baddr_d;
      caddr_q  <= caddr_d;
      wdata_q  <= wdata_d;
      rd_v_q   <= rd_v_d;
      rd_f_q   <= rd_f_d;
      dat_v_q  <= rd_v_q;
      dat_f_q  <= rd_f_q;
      valid_q  <= valid_d;
      res_q    <= res_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fir_lane_mac #(
      .SW (SAMPLE_WIDTH),
      .CW (COEF_WIDTH),
      .AW (ACC_W)
    ) u_mac (
      .clk      (clkIn),
      .rst_n    (nResetIn),
      .en_i     (dat_v_q),
      .first_i  (dat_f_q),
      .sample_i (bufDataIn[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .coef_i   (coefDataIn),
      .acc_o    (acc[l])
    );

    assign red[l] = OUT_WIDTH'(round_shift_reduce(
                      MAXW'(acc[l]), OUT_SHIFT, OUT_WIDTH));
  end

  assign sampleReadyOut = ready_q;
  assign coefAddrOut    = caddr_q;
  assign bufAddrOut     = baddr_q;
  assign bufWrenOut     = wren_q;
  assign bufWrDataOut   = wdata_q;
  assign resultOut      = res_q;
  assign resultValidOut = valid_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed vectors for the FIR MAC engine (2 lanes, 4 taps)
// with behavioural coefficient ROM and delay-line RAM.
module tb_fir_mac_engine;

  localparam int SW = 16;
  localparam int CW = 16;
  localparam int L  = 2;
  localparam int T  = 4;
  localparam int OW = 16;
  localparam int OS = 0;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [L*SW-1:0] sample;
  logic            svalid;
  logic            sready;
  logic [AW-1:0]   caddr;
  logic [CW-1:0]   cdata;
  logic [AW-1:0]   baddr;
  logic            bwren;
  logic [L*SW-1:0] bwdata;
  logic [L*SW-1:0] bdata;
  logic [L*OW-1:0] res;
  logic            rvalid;
  logic            rready;

  logic [CW-1:0]   rom [T];
  logic [L*SW-1:0] ram [T];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cdata <= rom[caddr];
    bdata <= ram[baddr];
    if (bwren)
      ram[baddr] <= bwdata;
  end

  fir_mac_engine #(
    .SAMPLE_WIDTH (SW),
    .COEF_WIDTH   (CW),
    .LANES        (L),
    .TAPS         (T),
    .OUT_WIDTH    (OW),
    .OUT_SHIFT    (OS)
  ) dut (
    .clkIn          (clk),
    .nResetIn       (nrst),
    .sampleIn       (sample),
    .sampleValidIn  (svalid),
    .sampleReadyOut (sready),
    .coefAddrOut    (caddr),
    .coefDataIn     (cdata),
    .bufAddrOut     (baddr),
    .bufWrenOut     (bwren),
    .bufWrDataOut   (bwdata),
    .bufDataIn      (bdata),
    .resultOut      (res),
    .resultValidOut (rvalid),
    .resultReadyIn  (rready)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_sready"}, sready, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_wren"}, bwren, 0);
    chk({tag, "_baddr"}, baddr, 0);
    chk({tag, "_caddr"}, caddr, 0);
    chk({tag, "_res"}, res, 0);
    chk({tag, "_wdata"}, bwdata, 0);
  endtask

  task automatic release_and_clear();
    int n;
    n = 0;
    @(negedge clk);
    nrst = 1'b1;
    while (!sready && n < 20) begin
      @(negedge clk);
      if (!sready)
        n++;
    end
    chk("clear_len", n, T);
  endtask

  task automatic frame(input logic [15:0] s0, input logic [15:0] s1,
                       input logic [1:0] p, input logic [15:0] e0,
                       input logic [15:0] e1, input bit bp);
    int n;
    logic [1:0] ea;
    n = 0;
    while (!sready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", sready, 1);
    sample = {s1, s0};
    svalid = 1'b1;
    rready = !bp;
    @(negedge clk);
    svalid = 1'b0;
    chk("wr_en", bwren, 1);
    chk("wr_addr", baddr, p);
    chk("wr_data", bwdata, {s1, s0});
    for (int k = 0; k < T; k++) begin
      @(negedge clk);
      ea = 2'(int'(p) - k);
      chk("rd_addr", baddr, ea);
      chk("coef_addr", caddr, k);
    end
    n = T;
    while (!rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, T + 4);
    chk("res_lane0", res[15:0], e0);
    chk("res_lane1", res[31:16], e1);
    if (bp) begin
      repeat (10) begin
        @(negedge clk);
        chk("bp_valid", rvalid, 1);
        chk("bp_res", res, {e1, e0});
        chk("bp_sready", sready, 0);
      end
      rready = 1'b1;
    end
    @(negedge clk);
    chk("valid_drop", rvalid, 0);
    chk("sready_back", sready, 1);
  endtask

  task automatic run_impulse();
    frame(16'd1, 16'd0, 2'd0, 16'd1, 16'd0, 1'b0);
    frame(16'd0, 16'd0, 2'd1, 16'd2, 16'd0, 1'b0);
    frame(16'd0, 16'd0, 2'd2, 16'd3, 16'd0, 1'b0);
    frame(16'd0, 16'd0, 2'd3, 16'd4, 16'd0, 1'b0);
    frame(16'd0, 16'd0, 2'd0, 16'd0, 16'd0, 1'b0);
  endtask

  logic [15:0] sat0 [4];
  logic [15:0] sat1 [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef FIR_SATURATE_EN
    sat0 = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    sat1 = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
`else
    sat0 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    sat1 = '{16'h8000, 16'h0000, 16'h8000, 16'h0000};
`endif
    rom    = '{16'd1, 16'd2, 16'd3, 16'd4};
    for (int i = 0; i < T; i++)
      ram[i] = 32'hDEAD_BEEF;
    sample = '0;
    svalid = 1'b0;
    rready = 1'b1;
    nrst   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    release_and_clear();
    frame(16'd5, 16'hFFFD, 2'd0, 16'd5,  16'hFFFD, 1'b0);
    frame(16'd0, 16'd0,    2'd1, 16'd10, 16'hFFFA, 1'b0);
    frame(16'd0, 16'd0,    2'd2, 16'd15, 16'hFFF7, 1'b0);
    frame(16'd0, 16'd0,    2'd3, 16'd20, 16'hFFF4, 1'b0);

    run_impulse();

    frame(16'd7, 16'd100, 2'd1, 16'd7, 16'd100, 1'b1);

    @(negedge clk);
    sample = {16'd9, 16'd9};
    svalid = 1'b1;
    @(posedge clk);
    #1 svalid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b0;
    #1 check_idle_outputs("mid_reset");
    repeat (2) @(negedge clk);
    release_and_clear();
    run_impulse();

    rom = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    for (int i = 0; i < 4; i++)
      frame(16'h7FFF, 16'h8000, 2'(i + 1), sat0[i], sat1[i], 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
# fir_mac_engine

Multi-channel, parametrised FIR multiply-accumulate engine; the successor to the single-channel 8×8 M9K FIR datapath. Accepts one frame of LANES signed samples per handshake, stores it in a circular delay line held in an external word-wide buffer RAM, then runs TAPS MAC cycles against a shared coefficient ROM, one multiplier per lane. Produces a rounded, shifted frame of LANES results with a valid/ready handshake. Sits between the UART sample front end and the result sink.

## Interface
- SAMPLE_WIDTH, 16, signed sample bits per lane
- COEF_WIDTH, 16, signed coefficient bits
- LANES, 8, independent channels per frame
- TAPS, 1024, filter length (≥2, need not be a power of two)
- OUT_WIDTH, 16, result bits per lane
- OUT_SHIFT, 15, arithmetic right shift applied to accumulator before output
- clkIn  in  1  single clock, rising edge
- nResetIn  in  1  asynchronous, active-low reset
- sampleIn  in  LANES*SAMPLE_WIDTH  input frame, lane i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- sampleValidIn  in  1  frame valid
- sampleReadyOut  out  1  engine accepts frame
- coefAddrOut  out  $clog2(TAPS)  coefficient ROM address
- coefDataIn  in  COEF_WIDTH  ROM data, one-cycle registered read latency
- bufAddrOut  out  $clog2(TAPS)  buffer RAM address
- bufWrenOut  out  1  buffer write enable
- bufWrDataOut  out  LANES*SAMPLE_WIDTH  buffer write data
- bufDataIn  in  LANES*SAMPLE_WIDTH  buffer read data, one-cycle registered read latency
- resultOut  out  LANES*OUT_WIDTH  result frame
- resultValidOut  out  1  result valid
- resultReadyIn  in  1  sink accepts result

## Operation
- States: CLEAR, IDLE, WRITE, MAC, DRAIN, OUT.
- CLEAR (entered on reset release): writes zero to buffer addresses 0..TAPS-1, one per cycle; then IDLE. sampleReadyOut low.
- IDLE: sampleReadyOut=1; transfer on sampleValidIn&&sampleReadyOut; frame latched, go WRITE.
- WRITE: one cycle, bufWrenOut=1, bufAddrOut=wrPtr, bufWrDataOut=latched frame.
- MAC: k=0..TAPS-1 one per cycle; bufAddrOut=(wrPtr−k) mod TAPS with explicit wrap below 0; coefAddrOut=k. After k=TAPS-1, wrPtr advances (TAPS-1 wraps to 0); go DRAIN.
- DRAIN: 3 cycles, flushes read, product and accumulate stages.
- Per lane: product = sample×coef, signed, SAMPLE_WIDTH+COEF_WIDTH bits; accumulator ACC_WIDTH = SAMPLE_WIDTH+COEF_WIDTH+$clog2(TAPS), signed; tap 0 loads, later taps add. No accumulator overflow possible.
- Output stage: add 1<<(OUT_SHIFT-1) (omitted when OUT_SHIFT=0), arithmetic shift right by OUT_SHIFT, reduce to OUT_WIDTH (see Configuration); register into resultOut; go OUT.
- OUT: resultValidOut=1, resultOut stable until resultReadyIn; on transfer go IDLE. No new frame accepted while result pending.
- Reset: all outputs 0, wrPtr=0, state CLEAR on release. Reset mid-operation aborts immediately; partial result discarded; CLEAR re-runs.

## Timing
- Accepting edge = E0. WRITE during E0–E1. Address k issued during E(k+1)–E(k+2). Accumulate for tap k at E(k+4). Output register loads and resultValidOut rises at E(TAPS+4).
- resultValidOut falls on the edge where resultValidOut&&resultReadyIn; sampleReadyOut rises the same edge. Minimum frame period TAPS+5 cycles.
- CLEAR lasts TAPS cycles after reset release; sampleReadyOut rises at edge TAPS after release.
- Read-after-write: tap 0 reads the frame written in WRITE (separate cycles, no bypass needed).

## Configuration
- FIR_SATURATE_EN defined: shifted value clamped to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1] per lane.
- Not defined: low OUT_WIDTH bits taken (two's-complement wrap).

## Structure
- Package fir_mac_pkg: state enum, ACC_WIDTH derivation function, round/shift/reduce function (honours FIR_SATURATE_EN).
- Sub-module fir_lane_mac: per-lane product register, accumulator, load/add control; generated LANES times. Top holds FSM, pointers, address generation, handshakes.

## Test plan
Bench: LANES=2, TAPS=4, SAMPLE_WIDTH=COEF_WIDTH=OUT_WIDTH=16, OUT_SHIFT=0.
- Impulse: coefs {1,2,3,4}, frames lane0 = 1,0,0,0,0, lane1 = 0 -> lane0 results 1,2,3,4,0; lane1 all 0.
- Post-reset clear: release reset, sampleReadyOut low exactly 4 cycles; coefs {1,2,3,4}, first frame lane0=5 -> result 5 (no stale data).
- Latency: frame accepted at E0 -> resultValidOut rises at E8; address sequence 3,2,1,0 wrap checked at wrPtr=3.
- Backpressure: hold resultReadyIn low 10 cycles -> resultValidOut high, resultOut stable, sampleReadyOut low; accepted on release.
- Saturation: coefs all 32767, four frames 32767 -> with FIR_SATURATE_EN 32767; without, low 16 bits of 4×32767² (0x0004).
- Reset mid-MAC: assert nResetIn at E3 -> all outputs 0 immediately; after release, CLEAR then impulse test passes.
